// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle between the ALU controller and the
// iterative divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             ovf;

    modport master (
        output start, x, y,
        input  busy, done, q, r, dbz, ovf
    );

    modport slave (
        input  start, x, y,
        output busy, done, q, r, dbz, ovf
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: magnitudes are divided over WIDTH cycles, then one
// fix-up cycle applies the signs to quotient and remainder.
module seq_divider #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b1
) (
    input logic          clk,
    input logic          reset,
    seq_divider_if.slave bus
);
    localparam int unsigned    CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH:0]   dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH+1:0] shifted, trial;

    assign x_neg = SIGNED && bus.x[WIDTH-1];
    assign y_neg = SIGNED && bus.y[WIDTH-1];
    // The most-negative value maps onto itself, which is the correct unsigned magnitude.
    assign x_mag = x_neg ? (~bus.x + 1'b1) : bus.x;
    assign y_mag = y_neg ? (~bus.y + 1'b1) : bus.y;

    // Remainder stays below the divisor, so the top bit of shifted is always 0 and the
    // MSB of trial is a clean borrow flag.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        q_d        = q_q;
        r_d        = r_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.y == '0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                        q_d    = '1;
                        r_d    = bus.x;
                    end else begin
                        dvd_d      = x_mag;
                        dvs_d      = {1'b0, y_mag};
                        rem_d      = '0;
                        cnt_d      = '0;
                        qneg_d     = x_neg ^ y_neg;
                        rneg_d     = x_neg;
                        ovf_pend_d = SIGNED && (bus.x == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.y);
                        state_d    = StDiv;
                    end
                end
            end
            StDiv: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
                rem_d = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                q_d     = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
                r_d     = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
                ovf_d   = ovf_pend_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            q_q        <= q_d;
            r_q        <= r_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dbz  = dbz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider. It is the inverse counterpart of the team's combinational 16-bit Booth multiplier in the ALU.
- Takes a dividend x and divisor y and produces quotient and remainder over multiple clock cycles.
- Uses a start/busy/done handshake so the ALU controller can issue divides and stall until the result is ready.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SIGNED, 1, 1 = two's-complement divide truncating toward zero; 0 = unsigned divide.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- x  input  WIDTH  dividend, captured on the accepted start edge.
- y  input  WIDTH  divisor, captured on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; q and r are valid from this cycle.
- q  output  WIDTH  quotient, held until the next done.
- r  output  WIDTH  remainder, held until the next done.
- dbz  output  1  divide-by-zero flag, valid with done, held.
- ovf  output  1  quotient overflow flag, valid with done, held.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
  - Reset outputs: busy=0, done=0, q=0, r=0, dbz=0, ovf=0.
  - State returns to IDLE and the counter clears.
  - Reset mid-operation aborts the division with no done pulse; reset has priority over every other event.
- States: IDLE, DIV, FIX. busy = (state != IDLE).
- IDLE:
  - If start=1 and y!=0: latch |x| and |y| as (WIDTH+1)-bit magnitudes. For SIGNED=0 the magnitudes are the zero-extended operands.
  - Also latch sign_q = x[MSB]^y[MSB] and sign_r = x[MSB] (both forced to 0 when SIGNED=0). Clear the remainder accumulator and counter, then go to DIV.
  - If start=1 and y==0: stay in IDLE and the next cycle registers done=1, dbz=1, ovf=0, q = all ones, r = x (raw). Latency is 1 cycle.
- DIV: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1).
  - Each iteration: shift {rem, dvd} left 1 and trial-subtract the divisor magnitude from rem.
  - If the result is non-negative, keep it and set quotient bit = 1; otherwise restore rem and set bit = 0.
  - After the last iteration, go to FIX.
- FIX (one cycle):
  - q = sign_q ? -qmag : qmag, truncated to WIDTH bits.
  - r = sign_r ? -rmag : rmag.
  - ovf=1 only when SIGNED=1, x = most-negative value and y = -1. In that case q wraps to the most-negative value and r=0.
  - dbz=0. done=1 for this one cycle. State goes to IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH+1 (17 cycles for WIDTH=16); busy is high for cycles k+1..k+WIDTH+1. done and busy are never high together.
- Back-to-back: start may be asserted in the same cycle done is high (state is IDLE) and is accepted.
- Start while busy: start is ignored and x/y changes have no effect on the operation in flight.
- Result identity: q*y + r == x (mod 2^WIDTH); |r| < |y|; r has the sign of x or is 0.

Test Plan:
- SIGNED=1, x=100, y=7, start pulse -> done exactly 17 cycles later; q=14 (0x000E), r=2, dbz=0, ovf=0.
- x=-100 (0xFF9C), y=7 -> q=0xFFF2 (-14), r=0xFFFE (-2). Then x=100, y=-7 -> q=0xFFF2, r=0x0002.
- x=5, y=0 -> done 1 cycle after start; dbz=1, q=0xFFFF, r=0x0005, busy never asserted.
- x=0x8000, y=0xFFFF -> q=0x8000, r=0, ovf=1. Then x=0x8000, y=1 -> q=0x8000, ovf=0.
- Handshake and reset:
  - Start 100/7; pulse start with 1/1 at cycle 5 -> ignored, final q=14.
  - Assert reset at cycle 10 of a new op -> busy=0 next cycle, no done, outputs 0.
  - New start after reset completes normally.
- SIGNED=0, x=0xFFFF, y=0x0002 -> q=0x7FFF, r=1. Then back-to-back start in the done cycle with 0x0010/0x0004 -> q=4, r=0.
